// File: rtl/simon_autoplayer_pkg.sv
// Shared mode encodings, state codes and small helpers for the Simon autoplayer.
// The Simon control block decodes mode_leds with the same constants.
package simon_autoplayer_pkg;

    localparam logic [2:0] MODE_INPUT    = 3'b001;
    localparam logic [2:0] MODE_PLAYBACK = 3'b010;
    localparam logic [2:0] MODE_REPEAT   = 3'b100;
    localparam logic [2:0] MODE_DONE     = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_WATCH,
        ST_REPLAY,
        ST_DONE
    } ap_state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_HIGH,
        PH_LOW,
        PH_SAMPLE
    } pulse_ph_t;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [3:0] onehot2(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

endpackage

// File: rtl/simon_pulse_gen.sv
// One player-clock transaction: SETUP, HIGH, LOW, then a single sample cycle.
// pclk_o is a flop so an asynchronous reset drops it at once.
module simon_pulse_gen
    import simon_autoplayer_pkg::*;
#(
    parameter int HIGH_CYC  = 4,
    parameter int LOW_CYC   = 4,
    parameter int SETUP_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic pclk_o,
    output logic sample,
    output logic idle
);

    localparam int CMAX = (HIGH_CYC > LOW_CYC)
        ? ((HIGH_CYC > SETUP_CYC) ? HIGH_CYC : SETUP_CYC)
        : ((LOW_CYC > SETUP_CYC) ? LOW_CYC : SETUP_CYC);
    localparam int CW = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HIGH_LAST  = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] LOW_LAST   = CW'(LOW_CYC - 1);

    pulse_ph_t     r_ph, w_ph_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_pclk, w_pclk_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph   <= PH_IDLE;
            r_cnt  <= '0;
            r_pclk <= 1'b0;
        end else begin
            r_ph   <= w_ph_n;
            r_cnt  <= w_cnt_n;
            r_pclk <= w_pclk_n;
        end
    end

    always_comb begin
        w_ph_n   = r_ph;
        w_cnt_n  = r_cnt + 1'b1;
        w_pclk_n = r_pclk;
        unique case (r_ph)
            PH_IDLE: begin
                w_cnt_n = '0;
                if (go) w_ph_n = PH_SETUP;
            end
            PH_SETUP: if (r_cnt == SETUP_LAST) begin
                w_ph_n   = PH_HIGH;
                w_cnt_n  = '0;
                w_pclk_n = 1'b1;
            end
            PH_HIGH: if (r_cnt == HIGH_LAST) begin
                w_ph_n   = PH_LOW;
                w_cnt_n  = '0;
                w_pclk_n = 1'b0;
            end
            PH_LOW: if (r_cnt == LOW_LAST) begin
                w_ph_n  = PH_SAMPLE;
                w_cnt_n = '0;
            end
            PH_SAMPLE: begin
                w_ph_n  = PH_IDLE;
                w_cnt_n = '0;
            end
            default: begin
                w_ph_n   = PH_IDLE;
                w_cnt_n  = '0;
                w_pclk_n = 1'b0;
            end
        endcase
    end

    assign pclk_o = r_pclk;
    assign sample = (r_ph == PH_SAMPLE);
    assign idle   = (r_ph == PH_IDLE);

endmodule

// File: rtl/simon_autoplayer.sv
// Closed-loop Simon player: seeds a move, records the playback, replays it.
// The FSM, LFSR and sequence buffer live here; pulse timing is in simon_pulse_gen.
module simon_autoplayer
    import simon_autoplayer_pkg::*;
#(
    parameter int         MAX_LEN   = 16,
    parameter int         HIGH_CYC  = 4,
    parameter int         LOW_CYC   = 4,
    parameter int         SETUP_CYC = 2,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inject_err,
    input  logic [2:0] mode_leds,
    input  logic [3:0] pattern_leds,
    output logic [3:0] pattern,
    output logic       pclk_o,
    output logic [7:0] rounds,
    output logic       busy,
    output logic       fail,
    output logic       overflow
);

    localparam int IW = $clog2(MAX_LEN) + 1;
    localparam int AW = $clog2(MAX_LEN);
    localparam logic [IW-1:0] LEN_MAX = IW'(MAX_LEN);

    ap_state_t     r_state, w_state_n;
    logic [7:0]    r_lfsr, w_lfsr_n;
    logic [IW-1:0] r_idx, w_idx_n;
    logic [IW-1:0] r_len, w_len_n;
    logic          r_inj, w_inj_n;
    logic [3:0]    r_pat, w_pat_n;
    logic [7:0]    r_rounds, w_rounds_n;
    logic          r_fail, w_fail_n;
    logic          r_ovf, w_ovf_n;
    logic [3:0]    r_mem [MAX_LEN];

    logic          w_go, w_sample, w_idle, w_active, w_last;
    logic [IW-1:0] w_idx_inc;
    logic [3:0]    w_mem_rd;

    simon_pulse_gen #(
        .HIGH_CYC (HIGH_CYC),
        .LOW_CYC  (LOW_CYC),
        .SETUP_CYC(SETUP_CYC)
    ) u_pulse (
        .clk   (clk),
        .rst   (rst),
        .go    (w_go),
        .pclk_o(pclk_o),
        .sample(w_sample),
        .idle  (w_idle)
    );

    assign w_active  = (r_state == ST_SEED) || (r_state == ST_WATCH)
                    || (r_state == ST_REPLAY);
    assign w_go      = w_active && w_idle;
    assign w_idx_inc = r_idx + 1'b1;
    assign w_mem_rd  = r_mem[r_idx[AW-1:0]];
    assign w_last    = r_inj && (w_idx_inc == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_lfsr   <= SEED;
            r_idx    <= '0;
            r_len    <= '0;
            r_inj    <= 1'b0;
            r_pat    <= '0;
            r_rounds <= '0;
            r_fail   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_lfsr   <= w_lfsr_n;
            r_idx    <= w_idx_n;
            r_len    <= w_len_n;
            r_inj    <= w_inj_n;
            r_pat    <= w_pat_n;
            r_rounds <= w_rounds_n;
            r_fail   <= w_fail_n;
            r_ovf    <= w_ovf_n;
        end
    end

    // Playback is captured as the watch transaction launches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) r_mem[i] <= '0;
        end else if (r_state == ST_WATCH && w_go) begin
            r_mem[r_idx[AW-1:0]] <= pattern_leds;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_lfsr_n   = r_lfsr;
        w_idx_n    = r_idx;
        w_len_n    = r_len;
        w_inj_n    = r_inj;
        w_pat_n    = r_pat;
        w_rounds_n = r_rounds;
        w_fail_n   = r_fail;
        w_ovf_n    = r_ovf;
        unique case (r_state)
            ST_IDLE, ST_DONE: if (start) begin
                w_state_n = ST_SEED;
                w_fail_n  = 1'b0;
                w_ovf_n   = 1'b0;
                w_idx_n   = '0;
            end
            ST_SEED: begin
                if (w_go) begin
                    w_pat_n  = onehot2(r_lfsr[1:0]);
                    w_lfsr_n = lfsr_next(r_lfsr);
                end
                if (w_sample) begin
                    w_idx_n = '0;
                    if (mode_leds == MODE_PLAYBACK) begin
                        w_state_n = ST_WATCH;
                    end else begin
                        w_state_n = ST_DONE;
                        w_fail_n  = 1'b1;
                    end
                end
            end
            ST_WATCH: begin
                if (w_go) w_pat_n = '0;
                if (w_sample) begin
                    w_idx_n = w_idx_inc;
                    if (mode_leds == MODE_PLAYBACK) begin
                        if (w_idx_inc == LEN_MAX) begin
                            w_state_n = ST_DONE;
                            w_ovf_n   = 1'b1;
                        end
                    end else if (mode_leds == MODE_REPEAT) begin
                        w_state_n = ST_REPLAY;
                        w_len_n   = w_idx_inc;
                        w_idx_n   = '0;
                        w_inj_n   = inject_err;
                    end else begin
                        w_state_n = ST_DONE;
                        w_fail_n  = 1'b1;
                    end
                end
            end
            ST_REPLAY: begin
                if (w_go) w_pat_n = w_last ? rotl4(w_mem_rd) : w_mem_rd;
                if (w_sample) begin
                    w_idx_n = w_idx_inc;
                    if (mode_leds == MODE_REPEAT && w_idx_inc < r_len) begin
                        w_state_n = ST_REPLAY;
                    end else if (mode_leds == MODE_INPUT) begin
                        w_state_n  = ST_SEED;
                        w_idx_n    = '0;
                        w_rounds_n = (r_rounds == 8'hFF) ? r_rounds
                                                         : r_rounds + 8'd1;
                    end else begin
                        w_state_n = ST_DONE;
                        w_fail_n  = 1'b1;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
        if (w_state_n == ST_DONE) w_pat_n = '0;
    end

    assign pattern  = r_pat;
    assign rounds   = r_rounds;
    assign busy     = w_active;
    assign fail     = r_fail;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_simon_autoplayer.sv
// Directed bench: a behavioural Simon closes the loop around the autoplayer,
// with a scoreboard of recorded moves checked against every replay guess.
module tb_simon_autoplayer;

    localparam int ML = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       inject_err = 1'b0;
    logic [2:0] mode_leds = 3'b001;
    logic [3:0] pattern_leds = 4'b0000;
    logic [3:0] pattern;
    logic       pclk_o;
    logic [7:0] rounds;
    logic       busy;
    logic       fail;
    logic       overflow;

    int total = 0;
    int bad = 0;

    logic [3:0] seq[$];
    logic [3:0] sb[$];
    int         play_i, rep_i, n_watch;
    int         n_pulse = 0;
    int         beh = 0;
    bit         exp_inj = 1'b0;
    logic [7:0] lfsr_m = 8'hA5;
    logic [3:0] last_rep = 4'b0000;

    simon_autoplayer #(.MAX_LEN(ML)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .inject_err  (inject_err),
        .mode_leds   (mode_leds),
        .pattern_leds(pattern_leds),
        .pattern     (pattern),
        .pclk_o      (pclk_o),
        .rounds      (rounds),
        .busy        (busy),
        .fail        (fail),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_onehot(input logic [1:0] s);
        logic [3:0] r;
        r = 4'b0000;
        r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic [3:0] m_rotl(input logic [3:0] p);
        return {p[2:0], p[3]};
    endfunction

    function automatic logic [7:0] m_lfsr(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        seq.delete();
        sb.delete();
        play_i = 0;
        rep_i = 0;
        n_watch = 0;
        mode_leds = 3'b001;
        pattern_leds = 4'b0000;
    endtask

    // Simon reacts to each rising edge of the player clock
    task automatic model_step();
        logic [3:0] e;
        n_pulse++;
        case (mode_leds)
            3'b001: begin
                chk("seed_pat", 32'(pattern), 32'(m_onehot(lfsr_m[1:0])));
                lfsr_m = m_lfsr(lfsr_m);
                seq.push_back(pattern);
                play_i = 0;
                mode_leds = 3'b010;
                pattern_leds = seq[0];
                sb.push_back(seq[0]);
            end
            3'b010: begin
                n_watch++;
                if (beh == 1) begin
                    pattern_leds = 4'(n_watch);
                    sb.push_back(pattern_leds);
                end else begin
                    play_i++;
                    if (play_i == seq.size()) begin
                        mode_leds = 3'b100;
                        rep_i = 0;
                        pattern_leds = 4'b0000;
                    end else begin
                        pattern_leds = seq[play_i];
                        sb.push_back(seq[play_i]);
                    end
                end
            end
            3'b100: begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 32'(pattern), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    if (exp_inj && sb.size() == 0) e = m_rotl(e);
                    chk("replay", 32'(pattern), 32'(e));
                end
                last_rep = pattern;
                if (beh == 2) mode_leds = 3'b010;
                else if (pattern != seq[rep_i]) mode_leds = 3'b111;
                else begin
                    rep_i++;
                    if (rep_i == seq.size()) mode_leds = 3'b001;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_loop();
        forever begin
            @(posedge pclk_o);
            model_step();
        end
    endtask

    task automatic width_loop();
        time t;
        forever begin
            @(posedge pclk_o);
            t = $time;
            @(negedge pclk_o);
            if (!rst) chk("high_width", 32'($time - t), 32'd40);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        lfsr_m = 8'hA5;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_rounds(input logic [7:0] r, input int budget);
        int n = 0;
        while (rounds != r && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_rounds", 32'(rounds), 32'(r));
    endtask

    initial begin
        time t0, t1;
        int  n, np;
        fork
            model_loop();
            width_loop();
        join_none
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_pattern", 32'(pattern), 32'd0);
        chk("rst_pclk", 32'(pclk_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {rounds, fail, overflow}, 32'd0);
        rst = 1'b0;

        // first seed and reset in the middle of its high phase
        pulse_start();
        n = 0;
        while (pattern == 4'b0000 && n < 50) begin
            @(negedge clk);
            n++;
        end
        t0 = $time;
        n = 0;
        while (!pclk_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        t1 = $time;
        chk("seed0_pclk", 32'(pclk_o), 32'd1);
        chk("seed0_pat", 32'(pattern), 32'h2);
        chk("seed0_setup", 32'(t1 - t0), 32'd20);
        #7;
        rst = 1'b1;
        lfsr_m = 8'hA5;
        #1;
        chk("midrst_pclk", 32'(pclk_o), 32'd0);
        chk("midrst_outs", {pattern, rounds, busy, fail, overflow}, 32'd0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        np = n_pulse;
        repeat (30) @(negedge clk);
        chk("idle_no_pulse", 32'(n_pulse), 32'(np));
        chk("idle_busy", 32'(busy), 32'd0);

        // three clean rounds
        beh = 0;
        exp_inj = 1'b0;
        pulse_start();
        wait_rounds(8'd3, 3000);
        chk("r3_busy", 32'(busy), 32'd1);
        chk("r3_fail", 32'(fail), 32'd0);

        // corrupted last guess in round two
        do_reset();
        pulse_start();
        wait_rounds(8'd1, 2000);
        inject_err = 1'b1;
        exp_inj = 1'b1;
        wait_idle(2000);
        chk("inj_guess", 32'(last_rep), 32'h8);
        chk("inj_fail", 32'(fail), 32'd1);
        chk("inj_rounds", 32'(rounds), 32'd1);
        chk("inj_pattern", 32'(pattern), 32'd0);
        inject_err = 1'b0;
        exp_inj = 1'b0;

        // Simon never leaves playback
        do_reset();
        beh = 1;
        pulse_start();
        wait_idle(2000);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_fail", 32'(fail), 32'd0);
        chk("ovf_watch", 32'(n_watch), 32'(ML));
        repeat (40) @(negedge clk);
        chk("ovf_no_5th", 32'(n_watch), 32'(ML));
        chk("ovf_pclk", 32'(pclk_o), 32'd0);

        // playback mode reported during replay
        model_clear();
        beh = 2;
        pulse_start();
        wait_idle(2000);
        chk("bad_fail", 32'(fail), 32'd1);
        chk("bad_ovf_clr", 32'(overflow), 32'd0);
        chk("bad_pattern", 32'(pattern), 32'd0);

        // restart from DONE clears fail
        model_clear();
        beh = 0;
        pulse_start();
        chk("restart_fail", 32'(fail), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        wait_rounds(8'd1, 2000);
        chk("restart_ok", 32'(fail), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
